// File: rtl/mode_sel_pkg.sv
// Shared mode type, mode code constants and the up/down step helper.
package mode_sel_pkg;

  localparam int unsigned MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_GATES = 3'd0;
  localparam mode_t MODE_MXD   = 3'd1;
  localparam mode_t MODE_PWM   = 3'd2;
  localparam mode_t MODE_HEX7  = 3'd3;
  localparam mode_t MODE_ALU   = 3'd4;
  localparam mode_t MODE_FDC   = 3'd5;
  localparam mode_t MODE_RAM   = 3'd6;
  localparam mode_t MODE_DIR   = 3'd7;

  // Simultaneous up and down presses cancel; wrap is natural 3-bit modulo.
  function automatic mode_t mode_step(input mode_t cur, input logic up, input logic down);
    mode_t nxt;
    nxt = cur;
    if (up && !down) begin
      nxt = cur + mode_t'(1);
    end else if (down && !up) begin
      nxt = cur - mode_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a tick-sampled debounce counter.
// Output level flips after DB_SAMPLES consecutive ticks that disagree with it.
module btn_debounce #(
  parameter int unsigned DB_SAMPLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level
);

  localparam int unsigned CNT_W = 8;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      if (tick) begin
        if (sync_q[1] != level) begin
          if (cnt_q == CNT_W'(DB_SAMPLES - 1)) begin
            level <= ~level;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/mode_selector.sv
// Debounced up/down push-button mode selector with lock and change pulse.
// Optional long-press-to-zero on btn_up enabled by MODE_SELECTOR_LONGPRESS_EN.
module mode_selector
  import mode_sel_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned DB_SAMPLES   = 8,
  parameter int unsigned LONG_SAMPLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              lock,
  output logic [MODE_W-1:0] mode,
  output logic              mode_chg
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  // Elaboration-time parameter range checks.
  if (CLK_DIV < 2 || CLK_DIV > (1 << 20)) begin : g_bad_clk_div
    $error("mode_selector: CLK_DIV out of range");
  end
  if (DB_SAMPLES < 2 || DB_SAMPLES > 255) begin : g_bad_db_samples
    $error("mode_selector: DB_SAMPLES out of range");
  end
  if (LONG_SAMPLES < 1) begin : g_bad_long_samples
    $error("mode_selector: LONG_SAMPLES out of range");
  end

  logic [DIV_W-1:0] div_q;
  logic             tick_c;
  logic             up_lvl;
  logic             down_lvl;
  logic             up_prev_q;
  logic             down_prev_q;
  logic             up_press_c;
  logic             down_press_c;
  logic             long_fire_c;
  mode_t            mode_d;

  assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));

  // Free-running sample-tick prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick_c),
    .btn   (btn_up),
    .level (up_lvl)
  );

  btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_down (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick_c),
    .btn   (btn_down),
    .level (down_lvl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
    end else begin
      up_prev_q   <= up_lvl;
      down_prev_q <= down_lvl;
    end
  end

  assign up_press_c   = up_lvl & ~up_prev_q;
  assign down_press_c = down_lvl & ~down_prev_q;

`ifdef MODE_SELECTOR_LONGPRESS_EN
  localparam int unsigned LONG_W = $clog2(LONG_SAMPLES + 1);

  logic [LONG_W-1:0] long_cnt_q;
  logic              long_done_q;

  assign long_fire_c = tick_c && up_lvl && !long_done_q &&
                       (long_cnt_q == LONG_W'(LONG_SAMPLES - 1));

  // Hold counter; long_done_q limits the action to once per press.
  always_ff @(posedge clk) begin
    if (rst || !up_lvl) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
    end else if (long_fire_c) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b1;
    end else if (tick_c && !long_done_q) begin
      long_cnt_q <= long_cnt_q + LONG_W'(1);
    end
  end
`else
  assign long_fire_c = 1'b0;
`endif

  always_comb begin
    mode_d = mode;
    if (!lock) begin
      if (long_fire_c) begin
        mode_d = MODE_GATES;
      end else begin
        mode_d = mode_step(mode, up_press_c, down_press_c);
      end
    end
  end

  // mode_chg is registered alongside mode so it marks the first cycle of a new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= MODE_GATES;
      mode_chg <= 1'b0;
    end else begin
      mode     <= mode_d;
      mode_chg <= (mode_d != mode);
    end
  end

endmodule

// File: tb/tb_mode_selector.sv
// Self-checking bench for mode_selector: directed vector table, reset and
// long-press sequences, then randomized presses against a behavioural model.
module tb_mode_selector;

  localparam int unsigned CLK_DIV      = 4;
  localparam int unsigned DB_SAMPLES   = 3;
  localparam int unsigned LONG_SAMPLES = 10;
  localparam int          MAX_LAT      = 2 + DB_SAMPLES * CLK_DIV + 2;
  localparam int          GLITCH_MAX   = (DB_SAMPLES - 1) * CLK_DIV;
  localparam int          CLEAN_MIN    = DB_SAMPLES * CLK_DIV + 4;
  localparam int          IDLE_CYC     = 24;

  logic       clk;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       lock;
  logic [2:0] mode;
  logic       mode_chg;

  int checks;
  int errors;
  int cyc;
  int chg_count;
  int last_chg_cyc;
  int exp_mode;

  mode_selector #(
    .CLK_DIV      (CLK_DIV),
    .DB_SAMPLES   (DB_SAMPLES),
    .LONG_SAMPLES (LONG_SAMPLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .lock     (lock),
    .mode     (mode),
    .mode_chg (mode_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mode_chg) begin
      chg_count    = chg_count + 1;
      last_chg_cyc = cyc;
    end
  end

  typedef struct {
    logic  up;
    logic  dn;
    logic  lk;
    int    hold;
    int    exp_mode;
    int    exp_pulses;
    string name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
    end
  endtask

  // Reference: a clean, unlocked, uncontested press steps the mode modulo 8.
  function automatic int model_mode(input int cur, input logic up, input logic dn,
                                    input logic lk, input int hold);
    if (lk || hold <= GLITCH_MAX) return cur;
    if (up && !dn) return (cur + 1) % 8;
    if (dn && !up) return (cur + 7) % 8;
    return cur;
  endfunction

  // One button action: hold the buttons, release, let everything settle.
  task automatic action(input logic up, input logic dn, input logic lk, input int hold,
                        input int exp_m, input int exp_p, input string name);
    int c0;
    int start;
    @(negedge clk);
    lock = lk;
    @(negedge clk);
    c0       = chg_count;
    start    = cyc;
    btn_up   = up;
    btn_down = dn;
    repeat (hold) @(negedge clk);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (IDLE_CYC) @(negedge clk);
    lock = 1'b0;
    check({name, " mode"}, int'(mode), exp_m);
    check({name, " pulses"}, chg_count - c0, exp_p);
    if (exp_p > 0) check_le({name, " latency"}, last_chg_cyc - start, MAX_LAT);
  endtask

  initial begin
    int c0;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    chg_count = 0;
    last_chg_cyc = 0;
    rst      = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    lock     = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 20, 1, 1, "up_first"};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 20, 0, 1, "down_to_0"};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 20, 7, 1, "down_wrap_7"};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 20, 0, 1, "up_wrap_0"};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 20, 7, 1, "down_again_7"};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 5,  7, 0, "glitch_up"};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 20, 7, 0, "both_cancel"};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 20, 7, 0, "locked_up"};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 20, 0, 1, "after_unlock"};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 22, 1, 1, "up_step"};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 24, 1, 0, "locked_down"};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 3,  1, 0, "glitch_down"};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset mode", int'(mode), 0);
    check("reset mode_chg", int'(mode_chg), 0);
    rst = 1'b0;
    exp_mode = 0;

    foreach (vecs[i]) begin
      action(vecs[i].up, vecs[i].dn, vecs[i].lk, vecs[i].hold,
             vecs[i].exp_mode, vecs[i].exp_pulses, vecs[i].name);
      exp_mode = vecs[i].exp_mode;
    end

    // Reset mid-debounce: held button re-debounces as a fresh press.
    @(negedge clk);
    btn_up = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst mode", int'(mode), 0);
    check("midrst mode_chg", int'(mode_chg), 0);
    c0  = chg_count;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    btn_up = 1'b0;
    repeat (IDLE_CYC) @(negedge clk);
    check("midrst repress mode", int'(mode), 1);
    check("midrst repress pulses", chg_count - c0, 1);
    exp_mode = 1;

    // Long hold starting from mode 5.
    for (int k = 0; k < 4; k++) begin
      exp_mode = (exp_mode + 1) % 8;
      action(1'b1, 1'b0, 1'b0, 20, exp_mode, 1, "to_five");
    end
    @(negedge clk);
    c0     = chg_count;
    btn_up = 1'b1;
    repeat (30) @(negedge clk);
    check("long mid mode", int'(mode), 6);
    repeat (30) @(negedge clk);
    btn_up = 1'b0;
    repeat (IDLE_CYC) @(negedge clk);
`ifdef MODE_SELECTOR_LONGPRESS_EN
    check("long mode", int'(mode), 0);
    check("long pulses", chg_count - c0, 2);
    exp_mode = 0;
`else
    check("long mode", int'(mode), 6);
    check("long pulses", chg_count - c0, 1);
    exp_mode = 6;
`endif

    // Randomized presses against the model.
    for (int n = 0; n < 30; n++) begin
      logic up;
      logic dn;
      logic lk;
      int   hold;
      int   nxt;
      up   = 1'($urandom_range(0, 1));
      dn   = 1'($urandom_range(0, 1));
      lk   = ($urandom_range(0, 3) == 0);
      hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, GLITCH_MAX))
                                         : int'($urandom_range(CLEAN_MIN, 24));
      nxt  = model_mode(exp_mode, up, dn, lk, hold);
      action(up, dn, lk, hold, nxt, (nxt != exp_mode) ? 1 : 0, "rand");
      exp_mode = nxt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
